// File: rtl/rv32_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the rv32_lsu load/store unit.
//                Holds the MemOP codes, the FSM state encoding and the
//                byte-enable base patterns used by lane generation.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // MemOP encodings driven by the multi-cycle controller
    localparam logic [2:0] MOP_B    = 3'b000;
    localparam logic [2:0] MOP_H    = 3'b001;
    localparam logic [2:0] MOP_W    = 3'b010;
    localparam logic [2:0] MOP_BU   = 3'b100;
    localparam logic [2:0] MOP_HU   = 3'b101;
    localparam logic [2:0] MOP_IDLE = 3'b111;

    // Byte-enable base patterns, shifted into place by the low address bits
    localparam logic [3:0] BE_BYTE  = 4'b0001;
    localparam logic [3:0] BE_HALF  = 4'b0011;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/rv32_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_lsu_if
//  Description : Word-wide data-memory bus between the LSU and the data RAM.
//                master : LSU side (drives req/we/addr/be/wdata)
//                slave  : RAM side (drives ack/rdata)
//                mem_rdata is valid in the cycle mem_ack is high for reads.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv32_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface : rv32_lsu_if
`default_nettype wire

// File: rtl/rv32_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Purely combinational lane logic for the LSU.
//                - store byte enables and lane-replicated write data
//                - load lane select with sign/zero extension
//                - legality and misalignment detection
//  Ports       : op_i/we_i/alo_i  access type, direction, address bits [1:0]
//                wdata_i/rdata_i  raw store data / raw bus read word
//                be_o/wdata_o     bus byte enables / replicated store data
//                rdata_o          formatted load result
//                legal_o          op is a legal request for this direction
//                misalign_o       half/word access not naturally aligned
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic        we_i,
    input  logic [1:0]  alo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        legal_o,
    output logic        misalign_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side. Shifting the base pattern by the low address bits masks
    // misaligned halves to the containing half (a[0] drops out).
    always_comb begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        case (op_i)
            MOP_B, MOP_BU: begin
                be_o    = BE_BYTE << alo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MOP_H, MOP_HU: begin
                be_o    = BE_HALF << {alo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = BE_WORD;
                wdata_o = wdata_i;
            end
        endcase
        // Reads always fetch the full word; lane select happens on return
        if (!we_i) begin
            be_o = BE_WORD;
        end
    end

    // Load side
    always_comb begin
        case (alo_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = alo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (op_i)
            MOP_B:   rdata_o = {{24{w_byte[7]}}, w_byte};
            MOP_BU:  rdata_o = {24'd0, w_byte};
            MOP_H:   rdata_o = {{16{w_half[15]}}, w_half};
            MOP_HU:  rdata_o = {16'd0, w_half};
            default: rdata_o = rdata_i;
        endcase
    end

    // Legality: unsigned variants only exist for loads
    always_comb begin
        case (op_i)
            MOP_B, MOP_H, MOP_W: legal_o = 1'b1;
            MOP_BU, MOP_HU:      legal_o = ~we_i;
            default:             legal_o = 1'b0;
        endcase

        case (op_i)
            MOP_H, MOP_HU: misalign_o = alo_i[0];
            MOP_W:         misalign_o = |alo_i;
            default:       misalign_o = 1'b0;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/rv32_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_lsu
//  Description : RV32I load/store unit. Accepts the controller's memory
//                request (MemWr/MemOP), runs one word access on the data
//                bus with byte enables and a req/ack handshake, then pulses
//                lsu_ready for one cycle. Load results are formatted and held
//                in lsu_rdata until the next load completes.
//  Ports       : clk, rst            clock, asynchronous active-high reset
//                MemWr, MemOP        request direction and access type
//                lsu_addr, lsu_wdata byte address and store data
//                lsu_ready           one-cycle completion pulse
//                lsu_err             (LSU_MISALIGN_TRAP_EN only) error pulse
//                lsu_rdata           formatted load result
//                bus                 rv32_lsu_if master modport
//  Options     : LSU_MISALIGN_TRAP_EN - misaligned half/word and illegal
//                requests complete without a bus access and raise lsu_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWr,
    input  logic [2:0]        MemOP,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_ready,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              lsu_err,
`endif
    output logic [31:0]       lsu_rdata,
    rv32_lsu_if.master        bus
);

    lsu_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-3:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        op_q;
    logic [1:0]        alo_q;
    logic              ready_q;
    logic [31:0]       rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              err_q;
`endif

    logic              w_in_idle;
    logic [2:0]        w_op;
    logic              w_we;
    logic [1:0]        w_alo;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata_fmt;
    logic              w_legal;
    logic              w_misalign;
    logic              w_reject;

    // One aligner serves both directions: in IDLE it formats the incoming
    // store, in BUS it formats the returning read word with the captured op.
    assign w_in_idle = (state_q == ST_IDLE);
    assign w_op      = w_in_idle ? MemOP          : op_q;
    assign w_we      = w_in_idle ? MemWr          : we_q;
    assign w_alo     = w_in_idle ? lsu_addr[1:0]  : alo_q;

    lsu_align u_align (
        .op_i       (w_op),
        .we_i       (w_we),
        .alo_i      (w_alo),
        .wdata_i    (lsu_wdata),
        .rdata_i    (bus.mem_rdata),
        .be_o       (w_be),
        .wdata_o    (w_wdata),
        .rdata_o    (w_rdata_fmt),
        .legal_o    (w_legal),
        .misalign_o (w_misalign)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_reject = ~w_legal | w_misalign;
`else
    // Misaligned accesses are silently masked by the aligner
    logic w_unused_misalign;
    assign w_unused_misalign = w_misalign;
    assign w_reject          = ~w_legal;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            op_q    <= MOP_IDLE;
            alo_q   <= 2'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (MemOP != MOP_IDLE) begin
                        if (w_reject) begin
                            // Complete without touching the bus
                            state_q <= ST_RESP;
                            ready_q <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            err_q   <= 1'b1;
`else
                            rdata_q <= 32'd0;
`endif
                        end else begin
                            state_q <= ST_BUS;
                            req_q   <= 1'b1;
                            we_q    <= MemWr;
                            addr_q  <= lsu_addr[ADDR_W-1:2];
                            be_q    <= w_be;
                            wdata_q <= w_wdata;
                            op_q    <= MemOP;
                            alo_q   <= lsu_addr[1:0];
                        end
                    end
                end
                ST_BUS: begin
                    if (bus.mem_ack) begin
                        req_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_RESP;
                        if (!we_q) begin
                            rdata_q <= w_rdata_fmt;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign lsu_ready     = ready_q;
    assign lsu_rdata     = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign lsu_err       = err_q;
`endif

endmodule : rv32_lsu
`default_nettype wire

// File: tb/tb_rv32_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_lsu
//  Description : Self-checking bench for rv32_lsu. A table of directed
//                transactions with hand-computed results, plus hand-written
//                sequences for reset state and reset during a bus access.
//  Options     : LSU_MISALIGN_TRAP_EN selects the trapping expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_lsu;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              MemWr;
    logic [2:0]        MemOP;
    logic [31:0]       lsu_addr;
    logic [31:0]       lsu_wdata;
    logic              lsu_ready;
    logic [31:0]       lsu_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              lsu_err;
`endif

    rv32_lsu_if #(.ADDR_W(ADDR_W)) bus ();

    rv32_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWr     (MemWr),
        .MemOP     (MemOP),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_ready (lsu_ready),
`ifdef LSU_MISALIGN_TRAP_EN
        .lsu_err   (lsu_err),
`endif
        .lsu_rdata (lsu_rdata),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;      // word the RAM returns
        int          waits;   // ack delay in cycles
        int          lat;     // cycles from request to lsu_ready
        logic        bus;     // a bus access is expected
        logic [29:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rdata;   // lsu_rdata after completion
        logic        err;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic we, logic [2:0] op, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rd, int waits,
                                int lat, logic bsy, logic [29:0] maddr,
                                logic [3:0] be, logic [31:0] mwd,
                                logic [31:0] rdata, logic err);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.waits = waits; v.lat = lat; v.bus = bsy; v.maddr = maddr;
        v.be = be; v.mwd = mwd; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        int          waits;
        int          lat;
        int          req_cycles;
        logic        seen_req;
        logic        unstable;
        logic [29:0] s_addr;
        logic [3:0]  s_be;
        logic [31:0] s_wd;
        logic        s_we;
        logic [31:0] r_rdata;
        logic        r_err;
        string       tag;

        tag        = $sformatf("v%0d", idx);
        cyc        = 0;
        waits      = v.waits;
        lat        = -1;
        req_cycles = 0;
        seen_req   = 1'b0;
        unstable   = 1'b0;
        s_addr = '0; s_be = '0; s_wd = '0; s_we = 1'b0;
        r_rdata = '0; r_err = 1'b0;

        MemWr         = v.we;
        MemOP         = v.op;
        lsu_addr      = v.addr;
        lsu_wdata     = v.wdata;
        bus.mem_rdata = v.rd;
        bus.mem_ack   = 1'b0;

        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.mem_req) begin
                req_cycles++;
                if (!seen_req) begin
                    seen_req = 1'b1;
                    s_addr = bus.mem_addr; s_be = bus.mem_be;
                    s_wd = bus.mem_wdata;  s_we = bus.mem_we;
                end else if (bus.mem_addr !== s_addr || bus.mem_be !== s_be ||
                             bus.mem_wdata !== s_wd || bus.mem_we !== s_we) begin
                    unstable = 1'b1;
                end
                if (waits == 0) begin
                    bus.mem_ack = 1'b1;
                end else begin
                    bus.mem_ack = 1'b0;
                    waits--;
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (lsu_ready) begin
                lat     = cyc;
                r_rdata = lsu_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
                r_err   = lsu_err;
`endif
                break;
            end
        end

        MemOP       = 3'b111;
        bus.mem_ack = 1'b0;

        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " bus_used"}, {31'd0, seen_req}, {31'd0, v.bus});
        if (v.bus) begin
            chk({tag, " mem_addr"},  {2'b00, s_addr}, {2'b00, v.maddr});
            chk({tag, " mem_be"},    {28'd0, s_be}, {28'd0, v.be});
            chk({tag, " mem_wdata"}, s_wd, v.mwd);
            chk({tag, " mem_we"},    {31'd0, s_we}, {31'd0, v.we});
            chk({tag, " req_cycles"}, req_cycles, v.waits + 1);
            chk({tag, " req_stable"}, {31'd0, unstable}, 32'd0);
        end
        chk({tag, " rdata"}, r_rdata, v.rdata);
`ifdef LSU_MISALIGN_TRAP_EN
        chk({tag, " lsu_err"}, {31'd0, r_err}, {31'd0, v.err});
`endif

        // Pulse width and hold of the load result over the idle cycles
        @(posedge clk);
        #1;
        chk({tag, " ready_pulse"}, {31'd0, lsu_ready}, 32'd0);
        chk({tag, " req_after"}, {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " rdata_hold"}, lsu_rdata, v.rdata);
    endtask

    initial begin
        // 0x80F07F01 read back at word 0x40 for the lane tests
        vecs[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, 1, 30'h40, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        vecs[1]  = mk(1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 2, 1, 30'h40, 4'h8, 32'hA5A5A5A5, 32'h0, 0);
        vecs[2]  = mk(1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, 2, 1, 30'h40, 4'hC, 32'h12341234, 32'h0, 0);
        vecs[3]  = mk(1, 3'b000, 32'h100, 32'h0000005A, 32'h0, 1, 3, 1, 30'h40, 4'h1, 32'h5A5A5A5A, 32'h0, 0);
        vecs[4]  = mk(0, 3'b000, 32'h101, 32'h0, 32'h80F07F01, 0, 2, 1, 30'h40, 4'hF, 32'h0, 32'h0000007F, 0);
        vecs[5]  = mk(0, 3'b000, 32'h103, 32'h0, 32'h80F07F01, 0, 2, 1, 30'h40, 4'hF, 32'h0, 32'hFFFFFF80, 0);
        vecs[6]  = mk(0, 3'b100, 32'h102, 32'h0, 32'h80F07F01, 0, 2, 1, 30'h40, 4'hF, 32'h0, 32'h000000F0, 0);
        vecs[7]  = mk(0, 3'b001, 32'h102, 32'h0, 32'h80F07F01, 0, 2, 1, 30'h40, 4'hF, 32'h0, 32'hFFFF80F0, 0);
        vecs[8]  = mk(0, 3'b101, 32'h102, 32'h0, 32'h80F07F01, 0, 2, 1, 30'h40, 4'hF, 32'h0, 32'h000080F0, 0);
        vecs[9]  = mk(0, 3'b010, 32'h100, 32'h0, 32'h80F07F01, 3, 5, 1, 30'h40, 4'hF, 32'h0, 32'h80F07F01, 0);
        // Store must leave the held load result alone
        vecs[10] = mk(1, 3'b010, 32'h104, 32'h11223344, 32'h0, 0, 2, 1, 30'h41, 4'hF, 32'h11223344, 32'h80F07F01, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[11] = mk(0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, 0, 30'h0, 4'h0, 32'h0, 32'h80F07F01, 1);
        vecs[12] = mk(0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1, 0, 30'h0, 4'h0, 32'h0, 32'h80F07F01, 1);
        vecs[13] = mk(0, 3'b001, 32'h101, 32'h0, 32'h80F07F01, 0, 1, 0, 30'h0, 4'h0, 32'h0, 32'h80F07F01, 1);
        vecs[14] = mk(1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1, 0, 30'h0, 4'h0, 32'h0, 32'h80F07F01, 1);
`else
        vecs[11] = mk(0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, 0, 30'h0, 4'h0, 32'h0, 32'h0, 0);
        vecs[12] = mk(0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 2, 1, 30'h40, 4'hF, 32'h0, 32'hCAFEF00D, 0);
        vecs[13] = mk(0, 3'b001, 32'h101, 32'h0, 32'h80F07F01, 0, 2, 1, 30'h40, 4'hF, 32'h0, 32'h00007F01, 0);
        vecs[14] = mk(1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1, 0, 30'h0, 4'h0, 32'h0, 32'h0, 0);
`endif
        vecs[15] = mk(0, 3'b101, 32'h8002, 32'h0, 32'h9ABC5678, 1, 3, 1, 30'h2000, 4'hF, 32'h0, 32'h00009ABC, 0);

        rst           = 1'b1;
        MemWr         = 1'b0;
        MemOP         = 3'b111;
        lsu_addr      = 32'h0;
        lsu_wdata     = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("rst mem_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("rst mem_we",    {31'd0, bus.mem_we}, 32'd0);
        chk("rst mem_be",    {28'd0, bus.mem_be}, 32'd0);
        chk("rst mem_addr",  {2'b00, bus.mem_addr}, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst lsu_rdata", lsu_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a bus access with the ack withheld
        MemWr    = 1'b0;
        MemOP    = 3'b010;
        lsu_addr = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst req_before", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst req_async", {31'd0, bus.mem_req}, 32'd0);
        MemOP = 3'b111;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.mem_ack = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("late_ack req",   {31'd0, bus.mem_req}, 32'd0);
            chk("late_ack ready", {31'd0, lsu_ready}, 32'd0);
        end
        bus.mem_ack = 1'b0;
        chk("midrst rdata", lsu_rdata, 32'd0);
        @(posedge clk);
        #1;
        run_vec(100, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rv32_lsu
`default_nettype wire
